ijvm_fetch_ctrl: RTL and testbench
==================================

Name: ijvm_fetch_ctrl

Overview:
Instruction-fetch sequencer for the IJVM datapath. It owns the program counter and issues byte reads to method-area memory over a req/ack handshake. Fetched opcode/operand bytes are buffered in a 2-entry prefetch queue that feeds the MBR side of the datapath. Microcode pops bytes from the queue and redirects fetch on branches/invokes through a jump load from the C bus.

Parameters:
WORD_WIDTH, 8, width of PC and memory address.
DATA_WIDTH, 8, width of a fetched bytecode byte (fixed at 8 for IJVM; parameter for bench reuse).

Ports:
clk  input  1  system clock; all state changes on posedge.
rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
jump_en  input  1  load PC from jump_addr and flush fetch stream this cycle.
jump_addr  input  WORD_WIDTH  new PC value (from C bus).
mbr_pop  input  1  consumer takes head byte; effective only when mbr_valid=1.
mbr_out  output  DATA_WIDTH  head byte of prefetch queue; 0 when empty.
mbr_valid  output  1  queue non-empty.
pc_out  output  WORD_WIDTH  address of next byte to be fetched.
mem_addr  output  WORD_WIDTH  fetch address.
mem_rd  output  1  fetch request.
mem_ack  input  1  memory has mem_data valid this cycle; ignored when mem_rd=0.
mem_data  input  DATA_WIDTH  returned byte.
busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n=0 at posedge): pc=0, queue count=0, state=IDLE, mem_rd=0, mem_addr=0, mbr_out=0, mbr_valid=0, busy=0. Reset overrides everything, including an outstanding fetch. Any later stale mem_ack is ignored because mem_rd=0.
- States: IDLE, FETCH, DISCARD. All outputs are registered.
- IDLE: if jump_en=0 and count<2, drive mem_rd=1 and mem_addr=pc next cycle; go to FETCH. Otherwise stay in IDLE.
- FETCH: mem_rd and mem_addr are held stable until mem_ack=1.
  - On mem_ack (no jump): push mem_data to queue tail, pc<=pc+1 (mod 2^WORD_WIDTH, 0xFF wraps to 0x00), mem_rd<=0, go to IDLE.
  - Minimum 2 cycles per byte (issue, then ack plus re-issue gap).
- DISCARD: mem_rd is held until mem_ack. The returned byte is dropped and pc is unchanged; then go to IDLE.
- Only one request is outstanding at a time. Fetches issue only when count<2, so a push never overflows.
- jump_en has the highest priority in all states:
  - Queue is flushed (count=0, mbr_valid=0 next cycle) and pc<=jump_addr.
  - IDLE: stay in IDLE. Next fetch issues the following cycle at jump_addr.
  - FETCH with mem_ack=0 same cycle: go to DISCARD.
  - FETCH with mem_ack=1 same cycle: byte dropped, go to IDLE.
  - DISCARD: pc reloaded, remain in DISCARD until ack.
  - A mbr_pop in the same cycle as jump_en has no separate effect (flush wins).
- Pop: mbr_pop=1 with count>0 removes head, count-1. mbr_pop when empty is ignored, with no underflow.
- Simultaneous push and pop: count unchanged. The head advances, and the new byte lands behind the remaining entry, or at head if count was 1.
- mbr_out always shows the head entry (registered queue, combinational head select allowed). It is 0 when count=0.
- pc_out equals the internal pc; during FETCH it equals mem_addr.

Test Plan:
- Reset then free-run with mem_ack returned 1 cycle after mem_rd and mem_data=addr+0x10, no pops -> reads at 0x00, 0x01, then mem_rd stays 0; queue holds 0x10, 0x11; pc_out=0x02.
- From the full queue above, pop once -> next cycle mbr_out=0x11, then fetch at 0x02 issues; after ack the queue reads 0x11, 0x12.
- Jump to 0x40 while FETCH at 0x05 is waiting (ack delayed 3 cycles) -> DISCARD, byte for 0x05 dropped, mbr_valid=0, next request at mem_addr=0x40.
- jump_en coincident with mem_ack -> returned byte not queued, state IDLE, next request at jump_addr.
- pc=0xFF fetch acked -> pc_out=0x00, next mem_addr=0x00.
- Assert rst_n=0 mid-FETCH, then stray mem_ack after release -> all outputs zero, queue empty, stray ack ignored, first request at 0x00.

Source files
------------

// File: rtl/ijvm_fetch_ctrl.sv
// IJVM instruction-fetch sequencer: owns the PC, fetches bytes over a req/ack
// handshake and buffers them in a 2-entry prefetch queue feeding the MBR.
module ijvm_fetch_ctrl #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_en,
  input  logic [WORD_WIDTH-1:0] jump_addr,
  input  logic                  mbr_pop,
  output logic [DATA_WIDTH-1:0] mbr_out,
  output logic                  mbr_valid,
  output logic [WORD_WIDTH-1:0] pc_out,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } state_e;

  state_e                state_q;
  logic [WORD_WIDTH-1:0] pc_q;
  logic [WORD_WIDTH-1:0] mem_addr_q;
  logic                  mem_rd_q;
  logic [DATA_WIDTH-1:0] q0_q, q0_d;
  logic [DATA_WIDTH-1:0] q1_q, q1_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push;
  logic                  pop;

  // A jump flushes the queue, so neither a returning byte nor a pop counts that cycle.
  assign push = (state_q == FETCH) && mem_ack && !jump_en;
  assign pop  = mbr_pop && (cnt_q != 2'd0) && !jump_en;

  // Pop is applied before push so a simultaneous push lands behind the survivor.
  always_comb begin
    q0_d  = q0_q;
    q1_d  = q1_q;
    cnt_d = cnt_q;
    if (jump_en) begin
      cnt_d = '0;
    end else begin
      if (pop) begin
        q0_d  = q1_q;
        cnt_d = cnt_q - 2'd1;
      end
      if (push) begin
        if (cnt_d == 2'd0) begin
          q0_d = mem_data;
        end else begin
          q1_d = mem_data;
        end
        cnt_d = cnt_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      cnt_q      <= '0;
      q0_q       <= '0;
      q1_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      q0_q  <= q0_d;
      q1_q  <= q1_d;
      unique case (state_q)
        IDLE: begin
          if (jump_en) begin
            pc_q <= jump_addr;
          end else if (cnt_q < 2'd2) begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= pc_q;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          if (jump_en) begin
            pc_q <= jump_addr;
            if (mem_ack) begin
              mem_rd_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              state_q <= DISCARD;
            end
          end else if (mem_ack) begin
            pc_q     <= pc_q + WORD_WIDTH'(1);
            mem_rd_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        DISCARD: begin
          if (jump_en) begin
            pc_q <= jump_addr;
          end
          if (mem_ack) begin
            mem_rd_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          mem_rd_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign mbr_valid = (cnt_q != 2'd0);
  assign mbr_out   = (cnt_q != 2'd0) ? q0_q : '0;
  assign pc_out    = pc_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ijvm_fetch_ctrl.sv
// Bench for ijvm_fetch_ctrl: directed scenarios then random traffic, checked
// against a transaction-level model (byte queue, pc, one outstanding request).
module tb_ijvm_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic       mbr_pop;
  logic [7:0] mbr_out;
  logic       mbr_valid;
  logic [7:0] pc_out;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic       busy;

  int unsigned ntests = 0;
  int unsigned nfail  = 0;

  // Reference model state
  logic [7:0]  mq[$];
  logic [7:0]  mpc;
  logic [7:0]  oaddr;
  bit          outst, disc;
  bit          rand_lat, stray_ack;
  int unsigned wcnt, lat, idle;
  bit          found;

  always #5 clk = ~clk;

  ijvm_fetch_ctrl #(
    .WORD_WIDTH(8),
    .DATA_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .mbr_pop   (mbr_pop),
    .mbr_out   (mbr_out),
    .mbr_valid (mbr_valid),
    .pc_out    (pc_out),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: memory responder drives ack, model advances on the edge, checks at negedge.
  task automatic step();
    bit          j, p, a, r;
    logic [7:0]  d, ja;
    int unsigned psz;
    if (rst_n && mem_rd && outst) begin
      mem_ack  = (wcnt >= lat);
      mem_data = oaddr + 8'h10;
    end else begin
      mem_ack  = stray_ack;
      mem_data = 8'($urandom);
    end
    j = jump_en; p = mbr_pop; a = mem_ack; d = mem_data; ja = jump_addr; r = rst_n;
    psz = mq.size();
    @(posedge clk);
    if (!r) begin
      mq.delete(); mpc = 8'h00; outst = 0; disc = 0; wcnt = 0;
    end else if (j) begin
      mq.delete();
      mpc = ja;
      if (outst) begin
        if (a) begin outst = 0; disc = 0; end
        else disc = 1;
      end
    end else begin
      if (p && mq.size() > 0) void'(mq.pop_front());
      if (outst && a) begin
        if (!disc) begin
          mq.push_back(d);
          mpc = mpc + 8'h01;
        end
        outst = 0; disc = 0;
      end
    end
    @(negedge clk);
    if (!r) begin
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_addr", mem_addr, 0);
    end else if (mem_rd === 1'b1 && !outst) begin
      chk("req_addr", mem_addr, mpc);
      chk("req_room", psz < 2, 1);
      outst = 1; disc = 0; oaddr = mem_addr; wcnt = 0;
      if (rand_lat) lat = $urandom_range(0, 3);
    end else if (mem_rd === 1'b1) begin
      chk("req_hold", mem_addr, oaddr);
      wcnt++;
    end
    chk("mem_rd", mem_rd, outst);
    chk("busy", busy, outst);
    chk("mbr_valid", mbr_valid, mq.size() != 0);
    chk("mbr_out", mbr_out, (mq.size() != 0) ? mq[0] : 8'h00);
    chk("pc_out", pc_out, mpc);
    if (r && !j && !outst && mq.size() < 2) idle++;
    else idle = 0;
    chk("issue_gap", idle <= 1, 1);
  endtask

  task automatic wait_req(input logic [7:0] a, input int unsigned budget);
    found = 0;
    for (int i = 0; i < budget; i++) begin
      if (mem_rd === 1'b1 && mem_addr === a) begin
        found = 1;
        break;
      end
      step();
    end
    chk("wait_req", found, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; jump_en = 0; jump_addr = 8'h00; mbr_pop = 0;
    mem_ack = 0; mem_data = 8'h00;
    mpc = 8'h00; oaddr = 8'h00; outst = 0; disc = 0;
    rand_lat = 0; stray_ack = 0; wcnt = 0; lat = 1; idle = 0;

    // Reset
    step(); step();
    chk("reset_mbr_valid", mbr_valid, 0);
    chk("reset_pc", pc_out, 8'h00);
    chk("reset_busy", busy, 0);

    // Free run, ack one cycle after request, no pops: queue fills with 0x10, 0x11
    rst_n = 1;
    for (int i = 0; i < 10; i++) step();
    chk("fill_head", mbr_out, 8'h10);
    chk("fill_pc", pc_out, 8'h02);
    chk("fill_rd", mem_rd, 0);

    // Pop once, refetch at 0x02
    mbr_pop = 1; step(); mbr_pop = 0;
    chk("pop_head", mbr_out, 8'h11);
    for (int i = 0; i < 4; i++) step();
    chk("refill_head", mbr_out, 8'h11);
    mbr_pop = 1; step(); mbr_pop = 0;
    chk("refill_second", mbr_out, 8'h12);

    // Jump away while a slow fetch at 0x05 is pending
    lat = 3;
    jump_en = 1; jump_addr = 8'h05; step(); jump_en = 0;
    wait_req(8'h05, 12);
    step();
    jump_en = 1; jump_addr = 8'h40; step(); jump_en = 0;
    chk("discard_valid", mbr_valid, 0);
    chk("discard_busy", busy, 1);
    chk("discard_pc", pc_out, 8'h40);
    chk("discard_hold_addr", mem_addr, 8'h05);
    wait_req(8'h40, 12);

    // Jump coincident with ack
    lat = 0;
    jump_en = 1; jump_addr = 8'h80; step(); jump_en = 0;
    chk("jack_valid", mbr_valid, 0);
    chk("jack_rd", mem_rd, 0);
    chk("jack_busy", busy, 0);
    chk("jack_pc", pc_out, 8'h80);
    step();
    chk("jack_next_rd", mem_rd, 1);
    chk("jack_next_addr", mem_addr, 8'h80);

    // PC wrap at 0xFF
    step();
    jump_en = 1; jump_addr = 8'hFF; step(); jump_en = 0;
    wait_req(8'hFF, 4);
    step();
    chk("wrap_pc", pc_out, 8'h00);
    chk("wrap_head", mbr_out, 8'h0F);
    step();
    chk("wrap_next_rd", mem_rd, 1);
    chk("wrap_next_addr", mem_addr, 8'h00);

    // Reset mid-fetch, then stray ack and empty pop after release
    lat = 5;
    step();
    rst_n = 0; step();
    chk("mid_rst_rd", mem_rd, 0);
    chk("mid_rst_out", mbr_out, 8'h00);
    chk("mid_rst_pc", pc_out, 8'h00);
    rst_n = 1; stray_ack = 1; mbr_pop = 1; step(); stray_ack = 0; mbr_pop = 0;
    chk("post_rst_rd", mem_rd, 1);
    chk("post_rst_addr", mem_addr, 8'h00);
    chk("post_rst_valid", mbr_valid, 0);

    // Random traffic
    rand_lat = 1;
    lat = $urandom_range(0, 3);
    for (int i = 0; i < 400; i++) begin
      jump_en   = ($urandom_range(0, 15) == 0);
      jump_addr = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      mbr_pop   = ($urandom_range(0, 2) == 0);
      step();
    end
    jump_en = 0; mbr_pop = 0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
